// File: rtl/alu_seq_pkg.sv
// Shared definitions for the wide ALU sequencer: ALU op encoding (common with
// the 32-bit ALU) and the sequencer state enum.
package alu_seq_pkg;

    localparam int ALU_WORD_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // Only ADD/SUB propagate carry/borrow between words.
    function automatic logic op_is_arith(alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Issues a wide ADD/SUB/OR/AND to an external 32-bit ALU one word per cycle,
// LS word first, chaining carry/borrow, and returns the assembled wide result.
module alu_wide_sequencer
    import alu_seq_pkg::*;
#(
    parameter int  WORD_W    = ALU_WORD_W,
    parameter int  NUM_WORDS = 2,
    localparam int DATA_W    = WORD_W * NUM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_cin,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [1:0]        alu_ctrl,
    input  logic [WORD_W-1:0] alu_out,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cout
);

    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    seq_state_e        r_state;
    alu_op_e           r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_rsp_cout;
    logic              r_rsp_valid;

    logic              w_run;
    logic              w_arith;
    alu_op_e           w_cmd_op;

    assign w_run    = (r_state == ST_RUN);
    assign w_arith  = op_is_arith(r_op);
    assign w_cmd_op = alu_op_e'(cmd_op);

    assign cmd_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_cout   = r_rsp_cout;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_ctrl = 2'b00;
        if (w_run) begin
            alu_a    = r_a[int'(r_idx) * WORD_W +: WORD_W];
            alu_b    = r_b[int'(r_idx) * WORD_W +: WORD_W];
            alu_cin  = r_carry & w_arith;
            alu_ctrl = r_op;
        end
    end

    // NOTE: state and datapath registers use <= so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_rsp_cout  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= w_cmd_op;
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_idx   <= '0;
                        r_carry <= op_is_arith(w_cmd_op) ? cmd_cin : 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[int'(r_idx) * WORD_W +: WORD_W] <= alu_out;
                    r_carry <= w_arith & alu_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_rsp_cout  <= w_arith & alu_cout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench: behavioural 32-bit ALU beside the DUT, wide-arithmetic
// reference model, directed test-plan vectors, random commands and back-to-back traffic.
module tb_alu_wide_sequencer;
    import alu_seq_pkg::*;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 2;
    localparam int DATA_W    = WORD_W * NUM_WORDS;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_cin;
    logic [WORD_W-1:0] alu_a;
    logic [WORD_W-1:0] alu_b;
    logic              alu_cin;
    logic [1:0]        alu_ctrl;
    logic [WORD_W-1:0] alu_out;
    logic              alu_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_cout;

    int n_vec    = 0;
    int n_miscmp = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_wide_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout)
    );

    // Stand-in for the team's combinational 32-bit ALU.
    always_comb begin
        alu_out  = '0;
        alu_cout = 1'b0;
        case (alu_ctrl)
            2'b00: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_cin};
            2'b01: begin
                alu_out  = alu_a - alu_b - {31'b0, alu_cin};
                alu_cout = ({1'b0, alu_a} < ({1'b0, alu_b} + {32'b0, alu_cin}));
            end
            2'b10: alu_out = alu_a | alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-operand reference: {carry/borrow out, result}.
    function automatic logic [DATA_W:0] ref_wide(input cmd_t c);
        logic [DATA_W:0] ea, eb, ec;
        ea = {1'b0, c.a};
        eb = {1'b0, c.b};
        ec = (DATA_W+1)'(c.cin);
        case (c.op)
            2'b00:   return ea + eb + ec;
            2'b01:   return {(ea < eb + ec), c.a - c.b - DATA_W'(c.cin)};
            2'b10:   return {1'b0, c.a | c.b};
            default: return {1'b0, c.a & c.b};
        endcase
    endfunction

    // Carry/borrow entering word w, derived from the low w words taken as whole numbers.
    function automatic logic carry_into(input cmd_t c, input int w);
        logic [DATA_W:0] mask, la, lb, ec, sum;
        if (c.op[1]) return 1'b0;
        if (w == 0) return c.cin;
        mask = ((DATA_W+1)'(1) << (w * WORD_W)) - 1'b1;
        la   = {1'b0, c.a} & mask;
        lb   = {1'b0, c.b} & mask;
        ec   = (DATA_W+1)'(c.cin);
        if (c.op == 2'b00) begin
            sum = la + lb + ec;
            return sum[w * WORD_W];
        end
        return (la < lb + ec);
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [DATA_W-1:0] v, input int w);
        return v[w * WORD_W +: WORD_W];
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op  = 2'($urandom_range(0, 3));
        c.a   = {$urandom, $urandom};
        c.b   = {$urandom, $urandom};
        c.cin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: c.a = '1;
            1: c.b = '1;
            2: c.a = '0;
            3: c.b = c.a;
            default: ;
        endcase
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c, input logic v);
        cmd_valid = v;
        cmd_op    = c.op;
        cmd_a     = c.a;
        cmd_b     = c.b;
        cmd_cin   = c.cin;
    endtask

    // Called at a negedge in IDLE; runs one command through to its response handshake.
    task automatic do_cmd(input cmd_t c, input int hold, input bit pre_next, input cmd_t nxt);
        logic [DATA_W:0] exp;
        exp = ref_wide(c);
        drive_cmd(c, 1'b1);
        check("idle_cmd_ready", 128'(cmd_ready), 128'(1));
        check("idle_alu_zero", 128'({alu_a, alu_b, alu_cin, alu_ctrl}), 128'(0));
        for (int w = 0; w < NUM_WORDS; w++) begin
            @(negedge clk);
            if (w == 0) drive_cmd(rand_cmd(), 1'b0);
            check("run_alu_a", 128'(alu_a), 128'(word_of(c.a, w)));
            check("run_alu_b", 128'(alu_b), 128'(word_of(c.b, w)));
            check("run_alu_ctrl", 128'(alu_ctrl), 128'(c.op));
            check("run_alu_cin", 128'(alu_cin), 128'(carry_into(c, w)));
            check("run_busy", 128'({cmd_ready, rsp_valid}), 128'(0));
        end
        @(negedge clk);
        check("rsp_valid", 128'(rsp_valid), 128'(1));
        check("rsp_data", 128'({rsp_cout, rsp_result}), 128'(exp));
        check("done_alu_zero", 128'({alu_a, alu_b, alu_cin, alu_ctrl}), 128'(0));
        check("done_cmd_ready", 128'(cmd_ready), 128'(0));
        for (int h = 0; h < hold; h++) begin
            if (pre_next) drive_cmd(nxt, 1'b1);
            @(negedge clk);
            check("hold_valid", 128'(rsp_valid), 128'(1));
            check("hold_data", 128'({rsp_cout, rsp_result}), 128'(exp));
            check("hold_cmd_ready", 128'(cmd_ready), 128'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 128'(rsp_valid), 128'(0));
        check("post_cmd_ready", 128'(cmd_ready), 128'(1));
    endtask

    // Back-to-back traffic monitor: scoreboard of expected responses and accept spacing.
    logic            mon_en = 1'b0;
    int              n_acc = 0;
    int              last_acc = -1;
    logic [DATA_W:0] exp_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(ref_wide('{op: cmd_op, a: cmd_a, b: cmd_b, cin: cmd_cin}));
                if (last_acc >= 0) check("b2b_accept_gap", 128'(cyc - last_acc), 128'(NUM_WORDS + 2));
                last_acc = cyc;
                n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("b2b_spurious_rsp", 128'(1), 128'(0));
                else check("b2b_result", 128'({rsp_cout, rsp_result}), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        cmd_t c, n, dummy;
        int   start, budget;
        dummy = '0;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        drive_cmd(dummy, 1'b0);
        #1;
        check("reset_cmd_ready", 128'(cmd_ready), 128'(1));
        check("reset_rsp", 128'({rsp_valid, rsp_cout, rsp_result}), 128'(0));
        check("reset_alu_zero", 128'({alu_a, alu_b, alu_cin, alu_ctrl}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test-plan vectors: carry across the word boundary, borrow, OR ignoring cin.
        c = '{op: 2'b00, a: 64'h0000_0000_FFFF_FFFF, b: 64'h1, cin: 1'b0};
        do_cmd(c, 0, 1'b0, dummy);
        c = '{op: 2'b01, a: 64'h0000_0001_0000_0000, b: 64'h1, cin: 1'b0};
        do_cmd(c, 0, 1'b0, dummy);
        c = '{op: 2'b10, a: 64'hF0F0_0000_0000_00FF, b: 64'h0F0F_0000_0000_FF00, cin: 1'b1};
        do_cmd(c, 0, 1'b0, dummy);

        // Backpressure with a new command waiting; it must go in on the first IDLE cycle.
        c = rand_cmd();
        n = rand_cmd();
        do_cmd(c, 5, 1'b1, n);
        do_cmd(n, 0, 1'b0, dummy);

        for (int k = 0; k < 20; k++) begin
            do_cmd(rand_cmd(), $urandom_range(0, 2), 1'b0, dummy);
        end

        // Reset during RUN word 1 discards the command.
        c = '{op: 2'b00, a: {$urandom, $urandom}, b: {$urandom, $urandom}, cin: 1'b1};
        drive_cmd(c, 1'b1);
        @(negedge clk);
        drive_cmd(c, 1'b0);
        @(negedge clk);
        check("pre_reset_word1", 128'(alu_a), 128'(word_of(c.a, 1)));
        rst_n = 1'b0;
        #1;
        check("midrun_reset_alu_zero", 128'({alu_a, alu_b, alu_cin, alu_ctrl}), 128'(0));
        check("midrun_reset_rsp", 128'({rsp_valid, rsp_cout, rsp_result}), 128'(0));
        check("midrun_reset_ready", 128'(cmd_ready), 128'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("after_reset_no_rsp", 128'(rsp_valid), 128'(0));
            check("after_reset_ready", 128'(cmd_ready), 128'(1));
        end

        // Back-to-back ADD stream with cmd_valid and rsp_ready held high.
        @(posedge clk);
        #1;
        mon_en    = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            c = rand_cmd();
            c.op = 2'b00;
            drive_cmd(c, 1'b1);
            start  = n_acc;
            budget = 0;
            do begin
                @(posedge clk);
                #1;
                budget++;
            end while (n_acc == start && budget < 20);
            if (n_acc == start) begin
                check("b2b_accept_timeout", 128'(1), 128'(0));
                break;
            end
        end
        cmd_valid = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("b2b_drained", 128'(exp_q.size()), 128'(0));
        check("b2b_accept_count", 128'(n_acc), 128'(12));
        mon_en    = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("final_idle", 128'({cmd_ready, rsp_valid}), 128'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
